// File: rtl/zombie_arena.sv
// Whack-a-zombie game core: LFSR-placed zombies, hit/penalty scoring,
// escape counting and a tick-based game clock.
module zombie_arena #(
  parameter int          N_HOLES    = 3,
  parameter int          GAME_TICKS = 30,
  parameter int          UP_TICKS   = 4,
  parameter int          SCORE_W    = 8,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] led,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [7:0]         time_left,
  output logic               gameover
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] btn_q, btn_d;
  logic [N_HOLES-1:0] led_q, led_d;
  logic [3:0]         up_cnt_q, up_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [7:0]         time_q, time_d;
  logic               gameover_q, gameover_d;

  logic [N_HOLES-1:0] edge_s;
  logic [N_HOLES-1:0] spawn_s;
  logic [7:0]         idx_s;
  logic               zombie_up_s;
  logic               hit_s;
  logic               wrong_s;
  logic [7:0]         lfsr_step_s;

  assign edge_s      = btn & ~btn_q;
  assign zombie_up_s = |led_q;
  // A hit needs the correct bit alone; any stray edge turns the press into a penalty.
  assign wrong_s     = zombie_up_s & (|(edge_s & ~led_q));
  assign hit_s       = zombie_up_s & (|(edge_s & led_q)) & ~wrong_s;
  assign lfsr_step_s = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign idx_s       = lfsr_q % 8'(N_HOLES);

  // Decode the LFSR-selected hole into a one-hot spawn pattern.
  always_comb begin
    spawn_s = {N_HOLES{1'b0}};
    for (int i = 0; i < N_HOLES; i++) begin
      spawn_s[i] = (idx_s == 8'(i));
    end
  end

  // Next-state logic for the game FSM and all registered outputs.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = (lfsr_q == 8'h00) ? SEED : lfsr_step_s;
    btn_d      = btn;
    led_d      = led_q;
    up_cnt_d   = up_cnt_q;
    score_d    = score_q;
    misses_d   = misses_q;
    time_d     = time_q;
    gameover_d = gameover_q;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d    = S_PLAY;
          led_d      = {N_HOLES{1'b0}};
          up_cnt_d   = 4'd0;
          score_d    = {SCORE_W{1'b0}};
          misses_d   = {SCORE_W{1'b0}};
          time_d     = 8'(GAME_TICKS);
          gameover_d = 1'b0;
        end else begin
          led_d = {N_HOLES{1'b0}};
        end
      end
      S_PLAY: begin
        if (zombie_up_s) begin
          if (hit_s) begin
            led_d = {N_HOLES{1'b0}};
            if (!(&score_q)) begin
              score_d = score_q + SCORE_W'(1);
            end else begin
              score_d = score_q;
            end
          end else if (wrong_s) begin
            if (|score_q) begin
              score_d = score_q - SCORE_W'(1);
            end else begin
              score_d = score_q;
            end
          end else begin
            score_d = score_q;
          end
          // A hit on the escaping tick takes priority over the escape.
          if (tick && !hit_s) begin
            if (up_cnt_q == 4'd1) begin
              led_d = {N_HOLES{1'b0}};
              if (!(&misses_q)) begin
                misses_d = misses_q + SCORE_W'(1);
              end else begin
                misses_d = misses_q;
              end
            end else begin
              up_cnt_d = up_cnt_q - 4'd1;
            end
          end else begin
            up_cnt_d = up_cnt_q;
          end
        end else begin
          led_d    = spawn_s;
          up_cnt_d = 4'(UP_TICKS);
        end

        if (tick) begin
          if (time_q == 8'd1) begin
            state_d    = S_FINISH;
            time_d     = 8'd0;
            led_d      = {N_HOLES{1'b0}};
            gameover_d = 1'b1;
          end else begin
            time_d = time_q - 8'd1;
          end
        end else begin
          time_d = time_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        led_d      = {N_HOLES{1'b0}};
        gameover_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      btn_q      <= {N_HOLES{1'b0}};
      led_q      <= {N_HOLES{1'b0}};
      up_cnt_q   <= 4'd0;
      score_q    <= {SCORE_W{1'b0}};
      misses_q   <= {SCORE_W{1'b0}};
      time_q     <= 8'd0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_d;
      led_q      <= led_d;
      up_cnt_q   <= up_cnt_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      time_q     <= time_d;
      gameover_q <= gameover_d;
    end
  end

  assign led       = led_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign time_left = time_q;
  assign gameover  = gameover_q;

endmodule

// File: tb/tb_zombie_arena.sv
// Directed vector bench for zombie_arena with default parameters; zombie
// positions are predicted from an independent model of the specified LFSR.
module tb_zombie_arena;

  localparam int B_NONE = 0, B_HIT = 1, B_WRONG = 2, B_BOTH = 3, B_HOLD = 4, B_ALL = 5;
  localparam int L_ZERO = 0, L_SPAWN = 1, L_SAME = 2;

  typedef struct {
    logic       st;
    logic       tk;
    int         bm;
    int         lm;
    logic [7:0] score;
    logic [7:0] miss;
    logic [7:0] tl;
    logic       go;
  } row_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [2:0] btn;
  logic [2:0] led;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] time_left;
  logic       gameover;

  logic [7:0] m_lfsr;
  logic [2:0] exp_led;
  int         checks;
  int         errors;
  row_t       vec [0:23];

  zombie_arena dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .btn       (btn),
    .led       (led),
    .score     (score),
    .misses    (misses),
    .time_left (time_left),
    .gameover  (gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, stepping every cycle, seeded with 8'hA5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else if (m_lfsr == 8'h00) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] es, input logic [7:0] em,
                           input logic [7:0] et, input logic eg);
    check({tag, ".led"},       {5'd0, led}, {5'd0, exp_led});
    check({tag, ".score"},     score,       es);
    check({tag, ".misses"},    misses,      em);
    check({tag, ".time_left"}, time_left,   et);
    check({tag, ".gameover"},  {7'd0, gameover}, {7'd0, eg});
  endtask

  // Called at a falling edge: drive one cycle of inputs, then check after the rising edge.
  task automatic step(input string tag, input logic st, input logic tk, input int bm,
                      input int lm, input logic [7:0] es, input logic [7:0] em,
                      input logic [7:0] et, input logic eg);
    logic [2:0] rot;
    logic [2:0] pred;
    rot   = {exp_led[1:0], exp_led[2]};
    pred  = 3'b001 << (m_lfsr % 8'd3);
    start = st;
    tick  = tk;
    case (bm)
      B_NONE:  btn = 3'b000;
      B_HIT:   btn = exp_led;
      B_WRONG: btn = rot;
      B_BOTH:  btn = exp_led | rot;
      B_HOLD:  btn = btn;
      default: btn = 3'b111;
    endcase
    @(posedge clk);
    #1;
    if (lm == L_ZERO) exp_led = 3'b000;
    else if (lm == L_SPAWN) exp_led = pred;
    check_all(tag, es, em, et, eg);
    @(negedge clk);
  endtask

  initial begin
    int         m;
    int         lm;
    checks  = 0;
    errors  = 0;
    exp_led = 3'b000;
    rst_n   = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    btn     = 3'b000;

    vec[0]  = '{1'b1, 1'b0, B_NONE,  L_ZERO,  8'd0, 8'd0, 8'd30, 1'b0};
    vec[1]  = '{1'b0, 1'b0, B_NONE,  L_SPAWN, 8'd0, 8'd0, 8'd30, 1'b0};
    vec[2]  = '{1'b0, 1'b0, B_WRONG, L_SAME,  8'd0, 8'd0, 8'd30, 1'b0};
    vec[3]  = '{1'b0, 1'b0, B_NONE,  L_SAME,  8'd0, 8'd0, 8'd30, 1'b0};
    vec[4]  = '{1'b0, 1'b0, B_HIT,   L_ZERO,  8'd1, 8'd0, 8'd30, 1'b0};
    vec[5]  = '{1'b0, 1'b0, B_HOLD,  L_SPAWN, 8'd1, 8'd0, 8'd30, 1'b0};
    vec[6]  = '{1'b0, 1'b0, B_HOLD,  L_SAME,  8'd1, 8'd0, 8'd30, 1'b0};
    vec[7]  = '{1'b0, 1'b0, B_NONE,  L_SAME,  8'd1, 8'd0, 8'd30, 1'b0};
    vec[8]  = '{1'b0, 1'b0, B_HIT,   L_ZERO,  8'd2, 8'd0, 8'd30, 1'b0};
    vec[9]  = '{1'b1, 1'b0, B_NONE,  L_SPAWN, 8'd2, 8'd0, 8'd30, 1'b0};
    vec[10] = '{1'b0, 1'b0, B_WRONG, L_SAME,  8'd1, 8'd0, 8'd30, 1'b0};
    vec[11] = '{1'b0, 1'b0, B_NONE,  L_SAME,  8'd1, 8'd0, 8'd30, 1'b0};
    vec[12] = '{1'b0, 1'b0, B_BOTH,  L_SAME,  8'd0, 8'd0, 8'd30, 1'b0};
    vec[13] = '{1'b0, 1'b0, B_NONE,  L_SAME,  8'd0, 8'd0, 8'd30, 1'b0};
    vec[14] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd0, 8'd29, 1'b0};
    vec[15] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd0, 8'd28, 1'b0};
    vec[16] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd0, 8'd27, 1'b0};
    vec[17] = '{1'b0, 1'b1, B_NONE,  L_ZERO,  8'd0, 8'd1, 8'd26, 1'b0};
    vec[18] = '{1'b0, 1'b0, B_ALL,   L_SPAWN, 8'd0, 8'd1, 8'd26, 1'b0};
    vec[19] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd1, 8'd25, 1'b0};
    vec[20] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd1, 8'd24, 1'b0};
    vec[21] = '{1'b0, 1'b1, B_NONE,  L_SAME,  8'd0, 8'd1, 8'd23, 1'b0};
    vec[22] = '{1'b0, 1'b1, B_HIT,   L_ZERO,  8'd1, 8'd1, 8'd22, 1'b0};
    vec[23] = '{1'b0, 1'b0, B_NONE,  L_SPAWN, 8'd1, 8'd1, 8'd22, 1'b0};

    repeat (2) @(negedge clk);
    check_all("reset", 8'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), vec[i].st, vec[i].tk, vec[i].bm, vec[i].lm,
           vec[i].score, vec[i].miss, vec[i].tl, vec[i].go);
    end

    // Tick every cycle: escape after 4 ticks, respawn on the following tick.
    for (int k = 1; k <= 21; k++) begin
      m  = 1 + int'(k >= 4) + int'(k >= 9) + int'(k >= 14) + int'(k >= 19);
      lm = L_SAME;
      if (k == 4 || k == 9 || k == 14 || k == 19) lm = L_ZERO;
      if (k == 5 || k == 10 || k == 15 || k == 20) lm = L_SPAWN;
      step($sformatf("run%0d", k), 1'b0, 1'b1, B_NONE, lm, 8'd1, 8'(m), 8'(22 - k), 1'b0);
    end
    step("final_hit",    1'b0, 1'b1, B_HIT,  L_ZERO,  8'd2, 8'd5, 8'd0,  1'b1);
    step("finish_press", 1'b0, 1'b0, B_ALL,  L_ZERO,  8'd2, 8'd5, 8'd0,  1'b1);
    step("finish_tick",  1'b0, 1'b1, B_NONE, L_ZERO,  8'd2, 8'd5, 8'd0,  1'b1);
    step("restart",      1'b1, 1'b0, B_NONE, L_ZERO,  8'd0, 8'd0, 8'd30, 1'b0);
    step("restart_sp",   1'b0, 1'b0, B_NONE, L_SPAWN, 8'd0, 8'd0, 8'd30, 1'b0);
    step("restart_tk",   1'b0, 1'b1, B_NONE, L_SAME,  8'd0, 8'd0, 8'd29, 1'b0);

    // Asynchronous abort mid-game.
    #2;
    rst_n   = 1'b0;
    exp_led = 3'b000;
    #1;
    check_all("abort", 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_tick",  1'b0, 1'b1, B_NONE, L_ZERO,  8'd0, 8'd0, 8'd0,  1'b0);
    step("idle_press", 1'b0, 1'b0, B_ALL,  L_ZERO,  8'd0, 8'd0, 8'd0,  1'b0);
    step("idle_start", 1'b1, 1'b0, B_NONE, L_ZERO,  8'd0, 8'd0, 8'd30, 1'b0);
    step("idle_spawn", 1'b0, 1'b0, B_NONE, L_SPAWN, 8'd0, 8'd0, 8'd30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zombie_arena.md
ZOMBIE_ARENA -- requirements
Module: zombie_arena

Interface
REQ-001 Parameter N_HOLES, default 3, number of zombie holes / buttons / LEDs (legal 2..8).
REQ-002 Parameter GAME_TICKS, default 30, game length in tick strobes (legal 1..255).
REQ-003 Parameter UP_TICKS, default 4, ticks a zombie stays up before escaping (legal 1..15).
REQ-004 Parameter SCORE_W, default 8, width of score and miss counters.
REQ-005 Parameter SEED, default 8'hA5, nonzero LFSR reset value.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 tick  input  1  one-cycle game time-base strobe.
REQ-009 start  input  1  level; sampled each cycle, starts a game.
REQ-010 btn  input  N_HOLES  synchronised active-high buttons, bit i = hole i.
REQ-011 led  output  N_HOLES  one-hot active zombie position, registered.
REQ-012 score  output  SCORE_W  hits minus penalties, registered.
REQ-013 misses  output  SCORE_W  escaped zombies, registered.
REQ-014 time_left  output  8  remaining ticks, registered.
REQ-015 gameover  output  1  high in FINISH, registered.

Function
REQ-016 FSM states IDLE, PLAY, FINISH; IDLE->PLAY and FINISH->PLAY on start=1; start in PLAY ignored.
REQ-017 On entering PLAY: score=0, misses=0, time_left=GAME_TICKS, gameover=0, no zombie up.
REQ-018 In PLAY, tick decrements time_left; tick with time_left==1 -> FINISH next edge, time_left=0, led=0, gameover=1.
REQ-019 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every cycle in every state; an all-zero value reloads SEED.
REQ-020 In PLAY with no zombie up, a zombie spawns next edge at index = LFSR mod N_HOLES; led shows it, up-counter loads UP_TICKS.
REQ-021 Up-counter decrements on tick; tick with counter==1 and no hit -> escape: misses+1 (saturating at max), zombie cleared.
REQ-022 Button press = rising edge of btn bit (btn registered one cycle for edge detect); held buttons do not repeat.
REQ-023 Hit: edge only on the active zombie's bit -> score+1 (saturating at 2^SCORE_W-1), zombie cleared same edge.
REQ-024 Wrong press: any edge on a non-active bit (including mixed with the correct bit) -> score-1 (saturating at 0), zombie stays up.
REQ-025 Edges with no zombie up, or outside PLAY, have no effect.
REQ-026 Hit and escape in same cycle: hit wins, misses unchanged.
REQ-027 Hit/escape on the final game tick: counter update applied, then FINISH.
REQ-028 Cleared zombie respawns exactly one cycle later (one cycle with led=0).
REQ-029 In FINISH, score, misses held; led=0; gameover=1 until next start.

Reset
REQ-030 rst_n low asynchronously forces IDLE, led=0, score=0, misses=0, time_left=0, gameover=0, LFSR=SEED, btn edge register=0, no zombie up.
REQ-031 rst_n low mid-game aborts the game; after release block waits in IDLE for start.

Verification
REQ-032 Reset, start=1 one cycle -> time_left=30, score=0, led one-hot within 2 cycles.
REQ-033 Press bit matching led -> score=1, led=0 one cycle, new one-hot next cycle; holding button gives no second point.
REQ-034 Press wrong bit with score=0 -> score stays 0; with score=2 -> score=1; led unchanged.
REQ-035 No presses, 4 ticks -> misses=1 and respawn; hit on same cycle as 4th tick -> score+1, misses unchanged.
REQ-036 30 ticks -> gameover=1, time_left=0, led=0, presses ignored; start -> score=0, time_left=30, gameover=0.
REQ-037 rst_n low mid-game -> all outputs zero immediately, stays IDLE until start.
